// File: rtl/ntt_stage_scheduler_pkg.sv
// Shared defaults and FSM encoding for the NTT stage scheduler.
// NTT_SCHED_INVERSE_EN widens the twiddle address by one bit for the inverse-twiddle ROM half.
package ntt_stage_scheduler_pkg;

  localparam int NTT_N          = 256;
  localparam int NTT_LOGN       = 8;
  localparam int NTT_FIFO_DEPTH = 8;

`ifdef NTT_SCHED_INVERSE_EN
  localparam int TW_EXTRA = 1;
`else
  localparam int TW_EXTRA = 0;
`endif

  localparam int ST_W = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/ntt_stage_scheduler_if.sv
// Bus between the NTT stage scheduler and its RAM/ROM/butterfly surroundings.
// NTT_SCHED_INVERSE_EN adds the inverse input and a one-bit-wider tw_addr.
interface ntt_stage_scheduler_if
  import ntt_stage_scheduler_pkg::*;
#(
  parameter int LOGN = NTT_LOGN
) ();

  localparam int TW_W = LOGN - 1 + TW_EXTRA;

  logic            start;
  logic            busy;
  logic            done;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr_x;
  logic [LOGN-1:0] rd_addr_y;
  logic [TW_W-1:0] tw_addr;
  logic            bf_en;
  logic            bf_valid;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr_x;
  logic [LOGN-1:0] wr_addr_y;
  logic            err;
  logic [ST_W-1:0] state;
`ifdef NTT_SCHED_INVERSE_EN
  logic            inverse;
`endif

  // Handshake: bf_en is rd_en one cycle later (RAM/ROM data aligned); the pipeline has no
  // ready, so every bf_valid retires the oldest outstanding pair and is written back that cycle.
  modport master (
    input  start,
    input  bf_valid,
`ifdef NTT_SCHED_INVERSE_EN
    input  inverse,
`endif
    output busy,
    output done,
    output rd_en,
    output rd_addr_x,
    output rd_addr_y,
    output tw_addr,
    output bf_en,
    output wr_en,
    output wr_addr_x,
    output wr_addr_y,
    output err,
    output state
  );

  modport slave (
    output start,
    output bf_valid,
`ifdef NTT_SCHED_INVERSE_EN
    output inverse,
`endif
    input  busy,
    input  done,
    input  rd_en,
    input  rd_addr_x,
    input  rd_addr_y,
    input  tw_addr,
    input  bf_en,
    input  wr_en,
    input  wr_addr_x,
    input  wr_addr_y,
    input  err,
    input  state
  );

endinterface

// File: rtl/ntt_stage_scheduler_addr_fifo.sv
// Address FIFO holding {x, y} pairs of butterflies in flight; combinational head.
// DEPTH must be a power of two >= 2; a full FIFO accepts a push in a cycle that also pops.
module ntt_addr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Storage carries no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ntt_stage_scheduler.sv
// In-place radix-2 NTT sequencer: issues butterfly read/twiddle addresses stage by stage,
// tracks them in ntt_addr_fifo and writes back on bf_valid. Option: NTT_SCHED_INVERSE_EN.
module ntt_stage_scheduler
  import ntt_stage_scheduler_pkg::*;
#(
  parameter int N          = NTT_N,
  parameter int LOGN       = NTT_LOGN,
  parameter int FIFO_DEPTH = NTT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  ntt_stage_scheduler_if.master  bus
);

  localparam int JW = LOGN - 1;
  localparam int SW = $clog2(LOGN);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [JW-1:0] J_LAST = JW'(N / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);

  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [JW-1:0]   j_q, j_d;
  logic            err_q, err_d;
  logic            bf_en_q;

  logic            issue;
  logic            pop;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [2*LOGN-1:0] fifo_head;

  logic [LOGN-1:0] half, k, grp, addr_x, addr_y;
  logic [SW-1:0]   tw_shift;
  logic [JW-1:0]   tw_lo;

  // Butterfly j of stage s pairs x and x+half; the half bit of x is always zero.
  always_comb begin
    half     = LOGN'(1) << s_q;
    k        = {1'b0, j_q} & (half - LOGN'(1));
    grp      = {1'b0, j_q} >> s_q;
    addr_x   = ((grp << s_q) << 1) | k;
    addr_y   = addr_x | half;
    tw_shift = S_LAST - s_q;
    tw_lo    = k[JW-1:0] << tw_shift;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    err_d   = err_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ISSUE;
          s_d     = '0;
          j_d     = '0;
          err_d   = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (!fifo_full) begin
          issue = 1'b1;
          if (j_q == J_LAST) begin
            state_d = ST_DRAIN;
          end else begin
            j_d = j_q + JW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Waiting for the pipeline to empty keeps the next stage from reading stale data.
        if (fifo_count == '0) begin
          if (s_q < S_LAST) begin
            s_d     = s_q + SW'(1);
            j_d     = '0;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (bus.bf_valid && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      j_q     <= '0;
      err_q   <= 1'b0;
      bf_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      err_q   <= err_d;
      bf_en_q <= issue;
    end
  end

  assign pop = bus.bf_valid && !fifo_empty;

  ntt_addr_fifo #(
    .WIDTH (2 * LOGN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (issue),
    .din_i   ({addr_x, addr_y}),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.rd_en     = issue;
  assign bus.rd_addr_x = issue ? addr_x : '0;
  assign bus.rd_addr_y = issue ? addr_y : '0;
  assign bus.bf_en     = bf_en_q;
  assign bus.wr_en     = pop;
  assign bus.wr_addr_x = fifo_empty ? '0 : fifo_head[2*LOGN-1:LOGN];
  assign bus.wr_addr_y = fifo_empty ? '0 : fifo_head[LOGN-1:0];
  assign bus.err       = err_q;
  assign bus.state     = state_q;

`ifdef NTT_SCHED_INVERSE_EN
  logic inv_q, inv_d;

  assign inv_d = (state_q == ST_IDLE && bus.start) ? bus.inverse : inv_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inv_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
    end
  end

  assign bus.tw_addr = issue ? {inv_q, tw_lo} : '0;
`else
  assign bus.tw_addr = issue ? tw_lo : '0;
`endif

endmodule

// File: doc/ntt_stage_scheduler.md
# ntt_stage_scheduler

Control sequencer that drives the two-point NTT butterfly pipeline through a full in-place radix-2 NTT of N coefficients held in a dual-port coefficient RAM. For every stage and butterfly it generates read addresses, twiddle addresses and the butterfly `en` strobe. It tracks outstanding butterflies in an address FIFO and writes results back when the pipeline asserts `valid`. It moves only addresses and strobes; coefficient and twiddle data flow directly RAM/ROM → butterfly → RAM.

## Interface
- `N`, 256: transform length, power of two, ≥ 4.
- `LOGN`, 8: log2(N).
- `FIFO_DEPTH`, 8: outstanding-butterfly capacity, power of two; must be ≥ butterfly latency + 2 for full throughput.
- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `start` in 1: begin a transform; sampled only in IDLE.
- `busy` out 1: transform in progress.
- `done` out 1: one-cycle completion pulse.
- `rd_en` out 1: coefficient RAM and twiddle ROM read strobe; RAM/ROM read latency is 1 cycle.
- `rd_addr_x`, `rd_addr_y` out LOGN: butterfly operand addresses.
- `tw_addr` out LOGN-1: twiddle ROM address (LOGN with `NTT_SCHED_INVERSE_EN`).
- `bf_en` out 1: butterfly `en`, equal to `rd_en` delayed one cycle.
- `bf_valid` in 1: butterfly `valid`.
- `wr_en` out 1: RAM write strobe for `xout`/`yout`.
- `wr_addr_x`, `wr_addr_y` out LOGN: write-back addresses.
- `err` out 1: sticky error flag.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE on `start`. Clear stage `s` and butterfly index `j`. Clear `err`.
- ISSUE: each cycle with FIFO occupancy < FIFO_DEPTH, issue one butterfly:
  - `rd_en`=1, `half`=1<<s, `k`=j & (half-1), `grp`=j>>s.
  - `rd_addr_x`=grp·2·half + k; `rd_addr_y`=`rd_addr_x` + half.
  - `tw_addr`=k<<(LOGN-1-s).
  - Push {x, y} address pair into the FIFO and increment `j`.
  - When FIFO is full, hold `rd_en`=0 and do not advance `j`.
- After issuing j = N/2-1, go to DRAIN. This prevents read-after-write hazards between stages.
- DRAIN: wait until the FIFO is empty.
  - If s < LOGN-1: increment s, clear j, go to ISSUE.
  - Otherwise go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Write-back, in any state:
  - `wr_en`=`bf_valid`.
  - `wr_addr_x`/`wr_addr_y` = FIFO head, combinational.
  - Pop on `bf_valid`.
- Push and pop in the same cycle: occupancy is unchanged. A full FIFO accepts the push in a cycle that also pops.
- `bf_valid` with an empty FIFO sets `err` and is otherwise ignored, with `wr_en` forced to 0.
- `start` while busy is ignored.
- Reset mid-transform returns to IDLE and empties the FIFO. In-flight butterfly results are then discarded as errors (`err` set) unless the butterfly is also reset.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `bf_en`, `wr_en`, `err` = 0; all addresses = 0.
- `start` sampled high at edge T → ISSUE during cycle T+1, and first `rd_en` is in cycle T+1.
- `bf_en` is asserted in cycle T+2, aligned with RAM/ROM data.
- `busy`=1 from T+1 through the DONE cycle inclusive.
- Throughput is 1 butterfly/cycle when FIFO_DEPTH ≥ latency + 2.
- A stage with butterfly latency L (from `bf_en` to `bf_valid`) takes N/2 + L + 2 cycles.

## Configuration
- `NTT_SCHED_INVERSE_EN` defined:
  - Adds input `inverse` (1 bit), latched at `start`.
  - `tw_addr` widens to LOGN bits, with MSB = latched `inverse`, selecting the inverse-twiddle half of the ROM.
- Not defined: no `inverse` port; `tw_addr` is LOGN-1 bits, forward transform only.
- Scaling by N⁻¹ is out of scope in both cases.

## Structure
- `defines.v` holds `Datawidth`, `p`, and new `NTT_N`/`NTT_LOGN` defaults used for parameter defaults.
- One sub-module, `ntt_addr_fifo`: synchronous FIFO of width 2·LOGN and depth FIFO_DEPTH, with push, pop, full, empty, count and combinational head.

## Test plan
- N=8, butterfly model with L=5, start pulse:
  - Stage 0 issues (0,1,tw0),(2,3,tw0),(4,5,tw0),(6,7,tw0).
  - Stage 1 issues (0,2,0),(1,3,2),(4,6,0),(5,7,2).
  - Stage 2 issues (0,4,0),(1,5,1),(2,6,2),(3,7,3).
  - `done` arrives after 3·(4+5+2) cycles.
- N=8, L=12, FIFO_DEPTH=4: `rd_en` stalls after 4 issues. Write addresses still match issue order and no `rd_en` occurs while FIFO is full.
- Full NTT of N=256 against a golden model: RAM contents at `done` match the reference transform (mod `p`). With `NTT_SCHED_INVERSE_EN`, `inverse`=1: NTT then INTT yields N·input mod `p`.
- Spurious `bf_valid` in IDLE: `err`=1, `wr_en`=0. `err` clears on next `start`.
- `reset` low during stage 1: all outputs return to 0 asynchronously. A new `start` restarts from stage 0 with an empty FIFO.
- `start` held high throughout: exactly one transform per IDLE entry, and `done` pulses once per transform.
